// File: rtl/shift_counter_pkg.sv
// Shared constants and helpers for the ring/Johnson shift counter.
// Values are handled zero-extended to MAXW bits so one helper serves any width.
package shift_counter_pkg;

   localparam int MAXW = 64;
   localparam int MODE_RING = 0;
   localparam int MODE_JOHNSON = 1;

   function automatic int n_states(int width, int mode);
      return (mode == MODE_JOHNSON) ? 2 * width : width;
   endfunction

   function automatic logic [MAXW-1:0] reset_value(int width, int mode);
      logic [MAXW-1:0] rv;
      rv = '0;
      if (mode != MODE_JOHNSON && width > 0) rv[0] = 1'b1;
      return rv;
   endfunction

   // Johnson: a run of p ones anchored at bit 0 or at bit width-1
   function automatic logic is_legal(logic [MAXW-1:0] value, int width,
                                     int mode);
      int p;
      logic [MAXW-1:0] mask;
      logic [MAXW-1:0] lo;
      logic [MAXW-1:0] hi;
      p = 0;
      for (int i = 0; i < MAXW; i++) p += int'(value[i]);
      mask = ~({MAXW{1'b1}} << width);
      lo = {MAXW{1'b1}} >> (MAXW - p);
      hi = (lo << (width - p)) & mask;
      if ((value & ~mask) != '0) return 1'b0;
      if (mode == MODE_RING) return p == 1;
      return (value == lo) || (value == hi);
   endfunction

endpackage

// File: rtl/shift_ring_counter_if.sv
// Control and status bundle of the shift counter.
// The slave side is the counter, the master side is its user.
interface shift_ring_counter_if
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MODE  = MODE_JOHNSON
);
   localparam int IDXW = $clog2(n_states(WIDTH, MODE));

   logic             enable;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count_out;
   logic [IDXW-1:0]  state_idx;
   logic             wrap;
   logic             illegal;

   modport master (
      output enable, dir, load, load_value,
      input  count_out, state_idx, wrap, illegal
   );

   modport slave (
      input  enable, dir, load, load_value,
      output count_out, state_idx, wrap, illegal
   );
endinterface

// File: rtl/shift_counter_decode.sv
// Legality check and sequence index of a ring/Johnson counter value.
// Illegal values decode to index 0.
module shift_counter_decode
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MODE  = MODE_JOHNSON,
   parameter int IDXW  = 3
) (
   input  logic [WIDTH-1:0] value,
   output logic             legal,
   output logic [IDXW-1:0]  idx
);
   int pop_c;
   int pos_c;

   always_comb begin
      pop_c = 0;
      pos_c = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) begin
            pop_c = pop_c + 1;
            pos_c = i;
         end
      end
   end

   always_comb begin
      legal = is_legal(MAXW'(value), WIDTH, MODE);
      idx = '0;
      if (legal) begin
         if (MODE == MODE_JOHNSON) begin
            if (value[WIDTH-1]) idx = IDXW'(2 * WIDTH - pop_c);
            else idx = IDXW'(pop_c);
         end else begin
            idx = IDXW'(pos_c);
         end
      end
   end
endmodule

// File: rtl/shift_ring_counter.sv
// Parametrised ring/Johnson shift counter with load, direction,
// wrap pulse and illegal-state self-correction.
module shift_ring_counter
   import shift_counter_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int MODE         = MODE_JOHNSON,
   parameter int SELF_CORRECT = 1
) (
   input logic clk,
   input logic rst,
   shift_ring_counter_if.slave bus
);
   localparam int N = n_states(WIDTH, MODE);
   localparam int IDXW = $clog2(N);
   localparam logic [WIDTH-1:0] RV = WIDTH'(reset_value(WIDTH, MODE));
   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             illegal_q, illegal_d;

   logic             cur_legal;
   logic [IDXW-1:0]  cur_idx;
   logic             load_legal;
   logic [IDXW-1:0]  load_idx_unused;
   logic [WIDTH-1:0] step_val;

   shift_counter_decode #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .IDXW  (IDXW)
   ) u_cur_dec (
      .value (count_q),
      .legal (cur_legal),
      .idx   (cur_idx)
   );

   shift_counter_decode #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .IDXW  (IDXW)
   ) u_load_dec (
      .value (bus.load_value),
      .legal (load_legal),
      .idx   (load_idx_unused)
   );

   // Johnson inverts the bit fed back; ring rotates it unchanged
   always_comb begin
      step_val = count_q;
      unique case (1'b1)
         (MODE == MODE_JOHNSON) && !bus.dir:
            step_val = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
         (MODE == MODE_JOHNSON) && bus.dir:
            step_val = {~count_q[0], count_q[WIDTH-1:1]};
         (MODE != MODE_JOHNSON) && !bus.dir:
            step_val = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
         default:
            step_val = {count_q[0], count_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      count_d = count_q;
      wrap_d = 1'b0;
      illegal_d = 1'b0;
      if (bus.load) begin
         if (load_legal) begin
            count_d = bus.load_value;
         end else begin
            count_d = RV;
            illegal_d = 1'b1;
         end
      end else if (bus.enable) begin
         if (SELF_CORRECT != 0 && !cur_legal) begin
            count_d = RV;
            illegal_d = 1'b1;
         end else begin
            count_d = step_val;
            wrap_d = cur_legal &&
                     (bus.dir ? (cur_idx == '0) : (cur_idx == LAST));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= RV;
         wrap_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q <= wrap_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.count_out = count_q;
   assign bus.state_idx = cur_idx;
   assign bus.wrap = wrap_q;
   assign bus.illegal = illegal_q;
endmodule
